// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory: write enables, lane-shifted store
// word, alignment check and right-aligned zero-extended load extraction.
module mem_lane_align
   import dmem_pkg::*;
(
   input  mem_size_e   size,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic        misalign,
   output logic [31:0] rdata
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      be       = 4'b0000;
      wword    = wdata;
      misalign = 1'b0;
      rdata    = 32'h0;
      unique case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
            rdata = {24'h0, rword[{lane, 3'b000} +: 8]};
         end
         SZ_HALF: begin
            misalign = lane[0];
            be       = lane[1] ? 4'b1100 : 4'b0011;
            wword    = {2{wdata[15:0]}};
            rdata    = {16'h0, (lane[1] ? rword[31:16] : rword[15:0])};
         end
         SZ_WORD: begin
            misalign = (lane != 2'b00);
            be       = 4'b1111;
            rdata    = rword;
         end
         default: misalign = 1'b1;  // illegal size is reported like a misalignment
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline for
// LATENCY cycles per access, then commits the store or returns load data.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset_x,
   input  logic        i_memReq,
   input  logic        i_memWrite,
   input  logic [1:0]  i_memSize,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_stall,
   output logic        o_err
);

   localparam int AW = $clog2(DEPTH);

   state_e          state;
   logic [3:0]      count;
   logic            cap_write;
   mem_size_e       cap_size;
   logic [AW+1:0]   cap_addr;
   logic [31:0]     cap_wdata;

   logic            acc_write;
   mem_size_e       acc_size;
   logic [AW+1:0]   acc_addr;
   logic [31:0]     acc_wdata;
   logic [AW-1:0]   idx;
   logic [31:0]     rword;
   logic [31:0]     wword;
   logic [31:0]     rdata_ext;
   logic [3:0]      be;
   logic            misalign;
   logic            access;
   logic            unused_addr;

   logic [31:0]     mem [DEPTH];

   assign unused_addr = ^i_addr[31:AW+2];

   // With LATENCY==1 the access happens on the edge leaving IDLE, before the
   // capture register is loaded, so the live request is used there.
   assign acc_write = (state == ST_IDLE) ? i_memWrite             : cap_write;
   assign acc_size  = (state == ST_IDLE) ? mem_size_e'(i_memSize) : cap_size;
   assign acc_addr  = (state == ST_IDLE) ? i_addr[AW+1:0]         : cap_addr;
   assign acc_wdata = (state == ST_IDLE) ? i_wdata                : cap_wdata;

   assign idx   = acc_addr[AW+1:2];
   assign rword = mem[idx];

   assign access = reset_x &&
                   (((state == ST_IDLE) && i_memReq && (LATENCY == 1)) ||
                    ((state == ST_WAIT) && (count == 4'd1)));

   assign o_stall = (state == ST_WAIT) || ((state == ST_IDLE) && i_memReq);

   mem_lane_align u_align (
      .size     (acc_size),
      .lane     (acc_addr[1:0]),
      .wdata    (acc_wdata),
      .rword    (rword),
      .be       (be),
      .wword    (wword),
      .misalign (misalign),
      .rdata    (rdata_ext)
   );

   always_ff @(posedge clk or negedge reset_x) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_x) begin
         state     <= ST_IDLE;
         count     <= 4'd0;
         cap_write <= 1'b0;
         cap_size  <= SZ_BYTE;
         cap_addr  <= '0;
         cap_wdata <= 32'h0;
         o_rdata   <= 32'h0;
         o_ready   <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         o_ready <= 1'b0;
         o_err   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (i_memReq) begin
                  cap_write <= i_memWrite;
                  cap_size  <= mem_size_e'(i_memSize);
                  cap_addr  <= i_addr[AW+1:0];
                  cap_wdata <= i_wdata;
                  if (LATENCY > 1) begin
                     state <= ST_WAIT;
                     count <= 4'(LATENCY - 1);
                  end else begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) state <= ST_RESP;
            end
            default: state <= ST_IDLE;
         endcase
         if (access) begin
            o_ready <= 1'b1;
            o_err   <= misalign;
            if (misalign)        o_rdata <= 32'h0;
            else if (!acc_write) o_rdata <= rdata_ext;
         end
      end
   end

   // NOTE: the RAM array has no reset; contents stay undefined until written, which keeps it mappable to block RAM.
   always_ff @(posedge clk) begin
      if (access && acc_write && !misalign) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's MEM-stage interface (memReq / memWrite / memSize / address / store data).
- Models a multi-cycle synchronous data RAM: accepts one request, waits a parameterised latency, then commits the store or returns load data.
- Drives a stall to the hazard unit to freeze the pipeline while busy.
- Returned load data is right-aligned and zero-extended; the datapath applies sign extension using its isLoadSigned control.

Parameters:
- DEPTH, 1024, number of 32-bit words; a power of two.
- LATENCY, 2, cycles o_stall is high per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_x  in  1  asynchronous, active-low reset.
- i_memReq  in  1  access request from the MEM stage.
- i_memWrite  in  1  1 = store, 0 = load.
- i_memSize  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data; the relevant bytes are right-aligned.
- o_rdata  out  32  load data, right-aligned and zero-extended.
- o_ready  out  1  one-cycle completion pulse.
- o_stall  out  1  freeze request to the hazard unit.
- o_err  out  1  misaligned or illegal-size access; pulses together with o_ready.

Behaviour:
- Reset (async, reset_x=0):
  - state = IDLE, counter = 0, o_rdata = 0, o_ready = 0, o_err = 0, o_stall = 0.
  - Any pending access is dropped and no write is committed.
  - RAM contents are not cleared and are undefined until written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - o_stall = i_memReq (combinational).
  - On i_memReq=1, capture memWrite/size/addr/wdata.
  - Next state is WAIT with counter = LATENCY-1 when LATENCY>1, otherwise ACCESS.
- WAIT:
  - o_stall = 1.
  - Counter decrements each cycle; at counter==0 go to ACCESS.
  - Input ports are ignored; the captured copy is authoritative.
- ACCESS (the edge entering RESP):
  - Perform the RAM operation using the captured request.
  - Load: o_rdata is registered at this edge.
  - Store: byte-lane write at this edge; o_rdata keeps its previous value.
- RESP:
  - o_ready = 1, o_stall = 0, o_err per the alignment check.
  - Next state is IDLE unconditionally; a request presented in RESP belongs to the completing instruction and is ignored.
- Totals:
  - o_stall is high for exactly LATENCY cycles per access.
  - An access occupies LATENCY+1 cycles, so back-to-back accesses have a minimum spacing of LATENCY+1 cycles.
- Addressing:
  - word index = addr[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo 4*DEPTH.
  - Lane = addr[1:0].
- Store lanes:
  - byte: wdata[7:0] → lane addr[1:0].
  - half: wdata[15:0] → lanes addr[1]*2..+1.
  - word: all 4 lanes.
  - Untouched lanes keep their contents.
- Load extraction:
  - byte: {24'b0, lane byte}.
  - half: {16'b0, half}.
  - word: the full word.
- Errors:
  - Conditions: half with addr[0]=1; word with addr[1:0]≠0; size 11.
  - Timing is unchanged; RAM is not written and o_rdata = 0.
  - o_err is high only in the RESP cycle.
- o_rdata holds its value between completions.
- i_memReq deasserted in IDLE: no activity, all outputs low.

Decomposition:
- dmem_pkg holds:
  - memSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - State encodings (ST_IDLE, ST_WAIT, ST_RESP).
- Sub-module mem_lane_align (combinational), from size, addr[1:0] and wdata, produces:
  - 4-bit byte-enable.
  - Lane-shifted write word.
  - Misalign flag.
  - Right-aligned read-extraction function of the raw word.
- dmem_responder holds the FSM, counter, capture register and RAM array.

Test Plan:
- LATENCY=2, word store 0xDEADBEEF @0x100, then word load @0x100 → o_stall high 2 cycles per access, o_ready in the 3rd cycle, load o_rdata = 0xDEADBEEF, o_err = 0.
- After that word, byte store 0xAA @0x101, then half store 0x1234 @0x102 → word load @0x100 = 0x1234AAEF; byte load @0x103 = 0x00000012; half load @0x100 = 0x0000AAEF.
- Half load @0x101, word store @0x102 and size=11 @0x104 → each gives o_err=1 with o_ready, o_rdata = 0; a subsequent word load @0x100 is unchanged.
- Reset asserted in WAIT of a store 0x5555AAAA @0x200 → outputs go to 0 immediately; after release, word load @0x200 does not return 0x5555AAAA (it returns the prior written value 0x0 from a pre-store).
- LATENCY=1, DEPTH=1024, store 0x11 @0x0 and 0x22 @0x1000 → word load @0x0 = 0x22 (wrap); o_stall is 1 cycle per access, and back-to-back requests complete every 2 cycles.
